filter_mode_ctrl: RTL and testbench



---
 rtl/filter_mode_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_filter_mode_ctrl.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/filter_mode_ctrl.sv
// rtl/filter_mode_ctrl.sv - frame-aligned filter mode sequencer with flush blanking and geometry checks
module filter_mode_ctrl #(
    parameter logic [11:0] IMG_HDISP    = 12'd1280,
    parameter logic [11:0] IMG_VDISP    = 12'd720,
    parameter logic [1:0]  FLUSH_FRAMES = 2'd1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic [1:0]  req_mode,
    output logic        req_ready,
    input  logic        per_vs,
    input  logic        per_de,
    output logic [1:0]  mode,
    output logic        blank,
    output logic        busy,
    output logic        switch_done,
    output logic [15:0] frame_cnt,
    input  logic        err_clr,
    output logic        line_err,
    output logic        frame_err
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_PEND  = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    localparam logic [11:0] CNT_MAX = 12'hFFF;

    state_t      state_q, state_d;
    logic [1:0]  mode_q, mode_d;
    logic [1:0]  pend_mode_q, pend_mode_d;
    logic [1:0]  flush_cnt_q, flush_cnt_d;
    logic        blank_q, blank_d;
    logic        switch_done_q, switch_done_d;

    // vs_q/de_q are the one-cycle delayed copies of the sync inputs used for edge detection
    logic        vs_q, vs_d;
    logic        de_q, de_d;
    logic        fs, le;

    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic [11:0] pix_cnt_q, pix_cnt_d;
    logic [11:0] line_cnt_q, line_cnt_d;
    logic        frame_seen_q, frame_seen_d;
    logic        line_err_q, line_err_d;
    logic        frame_err_q, frame_err_d;

    logic [1:0]  applied_mode;
    logic        line_ev, frame_ev;

    assign fs = per_vs & ~vs_q;
    assign le = ~per_de & de_q;

    // State register and all registered outputs/counters
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_RUN;
            mode_q        <= 2'd0;
            pend_mode_q   <= 2'd0;
            flush_cnt_q   <= 2'd0;
            blank_q       <= 1'b0;
            switch_done_q <= 1'b0;
            vs_q          <= 1'b0;
            de_q          <= 1'b0;
            frame_cnt_q   <= 16'd0;
            pix_cnt_q     <= 12'd0;
            line_cnt_q    <= 12'd0;
            frame_seen_q  <= 1'b0;
            line_err_q    <= 1'b0;
            frame_err_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            mode_q        <= mode_d;
            pend_mode_q   <= pend_mode_d;
            flush_cnt_q   <= flush_cnt_d;
            blank_q       <= blank_d;
            switch_done_q <= switch_done_d;
            vs_q          <= vs_d;
            de_q          <= de_d;
            frame_cnt_q   <= frame_cnt_d;
            pix_cnt_q     <= pix_cnt_d;
            line_cnt_q    <= line_cnt_d;
            frame_seen_q  <= frame_seen_d;
            line_err_q    <= line_err_d;
            frame_err_q   <= frame_err_d;
        end
    end

    // Mode sequencing: requests are parked until a frame start, then optionally flushed
    always_comb begin
        state_d       = state_q;
        mode_d        = mode_q;
        pend_mode_d   = pend_mode_q;
        flush_cnt_d   = flush_cnt_q;
        blank_d       = blank_q;
        switch_done_d = 1'b0;
        req_ready     = 1'b1;
        // a request arriving on the frame start itself takes precedence over the parked one
        applied_mode  = req_valid ? req_mode : pend_mode_q;

        case (state_q)
            ST_RUN: begin
                if (req_valid && (req_mode != mode_q)) begin
                    pend_mode_d = req_mode;
                    state_d     = ST_PEND;
                end
            end
            ST_PEND: begin
                if (fs) begin
                    if (applied_mode == mode_q) begin
                        state_d = ST_RUN;
                    end else begin
                        mode_d = applied_mode;
                        if ((applied_mode != 2'd0) && (FLUSH_FRAMES != 2'd0)) begin
                            state_d     = ST_FLUSH;
                            flush_cnt_d = FLUSH_FRAMES;
                            blank_d     = 1'b1;
                        end else begin
                            state_d       = ST_RUN;
                            switch_done_d = 1'b1;
                        end
                    end
                end else if (req_valid) begin
                    pend_mode_d = req_mode;
                end
            end
            ST_FLUSH: begin
                req_ready = 1'b0;
                if (fs) begin
                    flush_cnt_d = flush_cnt_q - 2'd1;
                    if (flush_cnt_q == 2'd1) begin
                        blank_d       = 1'b0;
                        state_d       = ST_RUN;
                        switch_done_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // Geometry counters, frame counter and sticky error flags
    always_comb begin
        vs_d         = per_vs;
        de_d         = per_de;
        frame_cnt_d  = frame_cnt_q;
        pix_cnt_d    = pix_cnt_q;
        line_cnt_d   = line_cnt_q;
        frame_seen_d = frame_seen_q | fs;
        line_ev      = le && (pix_cnt_q != IMG_HDISP);
        // the first frame start after reset has no completed frame behind it
        frame_ev     = fs && frame_seen_q && (line_cnt_q != IMG_VDISP);

        if (fs) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
        end

        if (le) begin
            pix_cnt_d = 12'd0;
        end else if (per_de && (pix_cnt_q != CNT_MAX)) begin
            pix_cnt_d = pix_cnt_q + 12'd1;
        end

        if (fs) begin
            line_cnt_d = 12'd0;
        end else if (le && (line_cnt_q != CNT_MAX)) begin
            line_cnt_d = line_cnt_q + 12'd1;
        end

        // a new error in the same cycle as a clear keeps the flag set
        line_err_d  = (line_err_q & ~err_clr) | line_ev;
        frame_err_d = (frame_err_q & ~err_clr) | frame_ev;
    end

    assign mode        = mode_q;
    assign blank       = blank_q;
    assign busy        = (state_q != ST_RUN);
    assign switch_done = switch_done_q;
    assign frame_cnt   = frame_cnt_q;
    assign line_err    = line_err_q;
    assign frame_err   = frame_err_q;

endmodule

// File: tb/tb_filter_mode_ctrl.sv
// tb/tb_filter_mode_ctrl.sv - scoreboard bench for filter_mode_ctrl against a behavioural model
module tb_filter_mode_ctrl;

    localparam logic [11:0] H  = 12'd8;
    localparam logic [11:0] V  = 12'd4;
    localparam logic [1:0]  FL = 2'd1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic [1:0]  req_mode = 2'd0;
    logic        req_ready;
    logic        per_vs = 1'b0;
    logic        per_de = 1'b0;
    logic [1:0]  mode;
    logic        blank;
    logic        busy;
    logic        switch_done;
    logic [15:0] frame_cnt;
    logic        err_clr = 1'b0;
    logic        line_err;
    logic        frame_err;

    always #5 clk = ~clk;

    filter_mode_ctrl #(
        .IMG_HDISP(H),
        .IMG_VDISP(V),
        .FLUSH_FRAMES(FL)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req_valid(req_valid),
        .req_mode(req_mode),
        .req_ready(req_ready),
        .per_vs(per_vs),
        .per_de(per_de),
        .mode(mode),
        .blank(blank),
        .busy(busy),
        .switch_done(switch_done),
        .frame_cnt(frame_cnt),
        .err_clr(err_clr),
        .line_err(line_err),
        .frame_err(frame_err)
    );

    typedef struct {
        int mode;
        int blank;
        int busy;
        int done;
        int ready;
        int fcnt;
        int lerr;
        int ferr;
    } exp_t;

    exp_t sb_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    // Behavioural model: a parked request, a count of frames still to blank, plain counters
    int m_mode, m_pend, m_waiting, m_flush_left, m_done;
    int m_frames, m_pix, m_lines, m_seen, m_lerr, m_ferr, m_pvs, m_pde;

    task automatic model_step(input bit rst, input bit vs, input bit de,
                              input bit rv, input int rm, input bit clr);
        bit   fs, le, lev, fev;
        int   tgt;
        exp_t e;
        m_done = 0;
        if (rst) begin
            m_mode = 0; m_pend = 0; m_waiting = 0; m_flush_left = 0;
            m_frames = 0; m_pix = 0; m_lines = 0; m_seen = 0;
            m_lerr = 0; m_ferr = 0; m_pvs = 0; m_pde = 0;
        end else begin
            fs = vs && !m_pvs[0];
            le = !de && m_pde[0];
            if (m_flush_left > 0) begin
                if (fs) begin
                    m_flush_left = m_flush_left - 1;
                    if (m_flush_left == 0) m_done = 1;
                end
            end else if (m_waiting != 0) begin
                if (fs) begin
                    tgt = rv ? rm : m_pend;
                    m_waiting = 0;
                    if (tgt != m_mode) begin
                        m_mode = tgt;
                        if (tgt != 0 && int'(FL) > 0) m_flush_left = int'(FL);
                        else m_done = 1;
                    end
                end else if (rv) begin
                    m_pend = rm;
                end
            end else if (rv && rm != m_mode) begin
                m_pend = rm;
                m_waiting = 1;
            end
            if (fs) m_frames = (m_frames + 1) % 65536;
            lev = le && (m_pix != int'(H));
            fev = fs && (m_seen != 0) && (m_lines != int'(V));
            if (le) m_pix = 0;
            else if (de && m_pix < 4095) m_pix = m_pix + 1;
            if (fs) begin
                m_lines = 0;
                m_seen = 1;
            end else if (le && m_lines < 4095) begin
                m_lines = m_lines + 1;
            end
            m_lerr = ((m_lerr != 0 && !clr) || lev) ? 1 : 0;
            m_ferr = ((m_ferr != 0 && !clr) || fev) ? 1 : 0;
            m_pvs = vs;
            m_pde = de;
        end
        e.mode  = m_mode;
        e.blank = (m_flush_left > 0) ? 1 : 0;
        e.busy  = (m_waiting != 0 || m_flush_left > 0) ? 1 : 0;
        e.done  = m_done;
        e.ready = (m_flush_left == 0) ? 1 : 0;
        e.fcnt  = m_frames;
        e.lerr  = m_lerr;
        e.ferr  = m_ferr;
        sb_q.push_back(e);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Monitor: every cycle the DUT presents a response that is matched against the queue head
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                vectors++;
                chk("mode", int'(mode), e.mode);
                chk("blank", int'(blank), e.blank);
                chk("busy", int'(busy), e.busy);
                chk("switch_done", int'(switch_done), e.done);
                chk("req_ready", int'(req_ready), e.ready);
                chk("frame_cnt", int'(frame_cnt), e.fcnt);
                chk("line_err", int'(line_err), e.lerr);
                chk("frame_err", int'(frame_err), e.ferr);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: run did not complete, %0d vectors, %0d miscompares", vectors, miscompares);
        $fatal(1, "watchdog");
    end

    // One-shot stimulus events and per-frame event plan
    bit o_rv = 0, o_clr = 0, o_rst = 0, rand_en = 0;
    int o_rm = 0;
    int r1_line, r1_mode, r2_line, r2_mode, fs_rv, fs_rm, clr_line, rst_line, short_line;

    task automatic clear_ev();
        r1_line = -1; r1_mode = 0; r2_line = -1; r2_mode = 0;
        fs_rv = 0; fs_rm = 0; clr_line = -1; rst_line = -1; short_line = -1;
    endtask

    task automatic drive_cycle(input bit vs, input bit de);
        bit rv, clr, rst;
        int rm;
        @(negedge clk);
        rv = o_rv; rm = o_rm; clr = o_clr; rst = o_rst;
        if (rand_en) begin
            if (!o_rv) begin
                rv = ($urandom_range(0, 11) == 0);
                rm = int'($urandom_range(0, 3));
            end
            if (!o_clr) clr = ($urandom_range(0, 39) == 0);
        end
        o_rv = 0; o_clr = 0; o_rst = 0;
        rst_n     = !rst;
        per_vs    = vs;
        per_de    = de;
        req_valid = rv;
        req_mode  = rm[1:0];
        err_clr   = clr;
        model_step(rst, vs, de, rv, rm, clr);
    endtask

    task automatic send_frame(input int lines);
        int npix, gaps;
        o_rv = (fs_rv != 0); o_rm = fs_rm;
        drive_cycle(1, 0);
        drive_cycle(1, 0);
        drive_cycle(0, 0);
        drive_cycle(0, 0);
        for (int l = 0; l < lines; l++) begin
            npix = (l == short_line) ? 7 : int'(H);
            for (int p = 0; p < npix; p++) begin
                if (p == 0 && l == r1_line) begin o_rv = 1; o_rm = r1_mode; end
                if (p == 0 && l == r2_line) begin o_rv = 1; o_rm = r2_mode; end
                if (p == 3 && l == rst_line) o_rst = 1;
                drive_cycle(0, 1);
            end
            gaps = 2 + int'($urandom_range(0, 2));
            for (int g = 0; g < gaps; g++) begin
                if (g == 0 && l == clr_line) o_clr = 1;
                drive_cycle(0, 0);
            end
        end
        drive_cycle(0, 0);
        drive_cycle(0, 0);
        clear_ev();
    endtask

    initial begin
        clear_ev();
        // reset
        for (int i = 0; i < 3; i++) begin
            o_rst = 1;
            drive_cycle(0, 0);
        end
        // clean frames in bypass
        for (int i = 0; i < 3; i++) send_frame(int'(V));
        // switch to gaussian mid-frame, one flushed frame
        r1_line = 1; r1_mode = 1;
        send_frame(int'(V));
        send_frame(int'(V));
        send_frame(int'(V));
        send_frame(int'(V));
        // overwritten pending request, then a request dropped during flush
        r1_line = 0; r1_mode = 2; r2_line = 2; r2_mode = 3;
        send_frame(int'(V));
        r1_line = 1; r1_mode = 2;
        send_frame(int'(V));
        send_frame(int'(V));
        // bypass request coincident with the frame start overrides the parked mode
        r1_line = 1; r1_mode = 2;
        send_frame(int'(V));
        fs_rv = 1; fs_rm = 0;
        send_frame(int'(V));
        // geometry errors, clear, and set-wins-over-clear
        short_line = 1;
        send_frame(int'(V));
        send_frame(3);
        clr_line = 0;
        send_frame(int'(V));
        short_line = 2; clr_line = 2;
        send_frame(int'(V));
        // reset in the middle of a flush
        r1_line = 1; r1_mode = 1;
        send_frame(int'(V));
        rst_line = 1;
        send_frame(int'(V));
        send_frame(int'(V));
        // frame counter wrap from a preloaded value
        @(posedge clk);
        #2;
        force dut.frame_cnt_q = 16'hFFFE;
        #1;
        release dut.frame_cnt_q;
        m_frames = 16'hFFFE;
        send_frame(int'(V));
        send_frame(int'(V));
        // randomized geometry and traffic
        rand_en = 1;
        for (int f = 0; f < 25; f++) begin
            if ($urandom_range(0, 3) == 0) short_line = int'($urandom_range(0, 2));
            send_frame(int'($urandom_range(3, 5)));
        end
        rand_en = 0;
        drive_cycle(0, 0);
        for (int i = 0; i < 10; i++) begin
            if (sb_q.size() == 0) break;
            @(posedge clk);
            #2;
        end
        if (sb_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d responses outstanding, expected 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
